// File: rtl/config_controller.sv
// Cartridge configuration controller: the CPU bus writes shadow registers, and a COMMIT
// copies shadow to active in one cycle once the PI is held and has gone idle.
module config_controller #(
  parameter logic [25:0] DD_OFFSET_RST   = 26'h3BE_0000,
  parameter logic [25:0] SAVE_OFFSET_RST = 26'h3FE_0000,
  parameter int          TIMEOUT_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_request,
  input  logic        bus_write,
  input  logic [2:0]  bus_address,
  input  logic [31:0] bus_wdata,
  output logic        bus_ack,
  output logic [31:0] bus_rdata,
  input  logic        pi_busy,
  output logic        pi_hold,
  output logic        sdram_switch,
  output logic        sdram_writable,
  output logic        dd_enabled,
  output logic        sram_enabled,
  output logic        flashram_enabled,
  output logic        flashram_read_mode,
  output logic [25:0] dd_offset,
  output logic [25:0] save_offset,
  output logic        update_pending,
  output logic        update_timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]       CTRL_RST = 6'h3C;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DD     = 3'd1;
  localparam logic [2:0] ADDR_SAVE   = 3'd2;
  localparam logic [2:0] ADDR_COMMIT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [5:0]       shadow_ctrl, active_ctrl;
  // Offsets only hold bits [25:17]; the low bits are hard zero.
  logic [8:0]       shadow_dd, active_dd;
  logic [8:0]       shadow_save, active_save;

  logic wr, rd;
  logic unused_wdata;

  assign wr           = bus_request & bus_write;
  assign rd           = bus_request & ~bus_write;
  assign unused_wdata = ^{bus_wdata[31:26], bus_wdata[16:6]};

  assign sdram_switch       = active_ctrl[0];
  assign sdram_writable     = active_ctrl[1];
  assign dd_enabled         = active_ctrl[2];
  assign sram_enabled       = active_ctrl[3];
  assign flashram_enabled   = active_ctrl[4];
  assign flashram_read_mode = active_ctrl[5];
  assign dd_offset          = {active_dd, 17'b0};
  assign save_offset        = {active_save, 17'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      shadow_ctrl    <= CTRL_RST;
      active_ctrl    <= CTRL_RST;
      shadow_dd      <= DD_OFFSET_RST[25:17];
      active_dd      <= DD_OFFSET_RST[25:17];
      shadow_save    <= SAVE_OFFSET_RST[25:17];
      active_save    <= SAVE_OFFSET_RST[25:17];
      bus_ack        <= 1'b0;
      bus_rdata      <= '0;
      pi_hold        <= 1'b0;
      update_pending <= 1'b0;
      update_timeout <= 1'b0;
    end else begin
      bus_ack   <= bus_request;
      bus_rdata <= '0;
      if (rd) begin
        case (bus_address)
          ADDR_CTRL:   bus_rdata <= {26'b0, shadow_ctrl};
          ADDR_DD:     bus_rdata <= {6'b0, shadow_dd, 17'b0};
          ADDR_SAVE:   bus_rdata <= {6'b0, shadow_save, 17'b0};
          ADDR_STATUS: bus_rdata <= {30'b0, update_timeout, update_pending};
          default:     bus_rdata <= '0;
        endcase
      end
      if (wr) begin
        case (bus_address)
          ADDR_CTRL:   shadow_ctrl <= bus_wdata[5:0];
          ADDR_DD:     shadow_dd   <= bus_wdata[25:17];
          ADDR_SAVE:   shadow_save <= bus_wdata[25:17];
          ADDR_STATUS: if (bus_wdata[1]) update_timeout <= 1'b0;
          default: ;
        endcase
      end

      // Commit handshake; a timeout set in WAIT overrides a same-cycle STATUS clear.
      case (state)
        IDLE: begin
          if (wr && bus_address == ADDR_COMMIT) begin
            state          <= WAIT;
            count          <= '0;
            update_timeout <= 1'b0;
            pi_hold        <= 1'b1;
            update_pending <= 1'b1;
          end
        end
        WAIT: begin
          count <= count + 1'b1;
          if (!pi_busy) begin
            state <= APPLY;
          end else if (count == CNT_LAST) begin
            state          <= IDLE;
            update_timeout <= 1'b1;
            pi_hold        <= 1'b0;
            update_pending <= 1'b0;
          end
        end
        APPLY: begin
          active_ctrl    <= shadow_ctrl;
          active_dd      <= shadow_dd;
          active_save    <= shadow_save;
          state          <= IDLE;
          pi_hold        <= 1'b0;
          update_pending <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          pi_hold        <= 1'b0;
          update_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_controller.sv
// Directed bench for config_controller with a short commit timeout.
module tb_config_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_request;
  logic        bus_write;
  logic [2:0]  bus_address;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        pi_busy;
  logic        pi_hold;
  logic        sdram_switch, sdram_writable, dd_enabled, sram_enabled;
  logic        flashram_enabled, flashram_read_mode;
  logic [25:0] dd_offset, save_offset;
  logic        update_pending, update_timeout;

  int checks = 0;
  int fails  = 0;
  logic [31:0] rd;
  logic [5:0]  act;

  assign act = {flashram_read_mode, flashram_enabled, sram_enabled, dd_enabled,
                sdram_writable, sdram_switch};

  config_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .pi_busy(pi_busy), .pi_hold(pi_hold),
    .sdram_switch(sdram_switch), .sdram_writable(sdram_writable), .dd_enabled(dd_enabled),
    .sram_enabled(sram_enabled), .flashram_enabled(flashram_enabled),
    .flashram_read_mode(flashram_read_mode),
    .dd_offset(dd_offset), .save_offset(save_offset),
    .update_pending(update_pending), .update_timeout(update_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request for a cycle; return at the ack cycle's falling edge.
  task automatic bus_op(input logic w, input logic [2:0] a, input logic [31:0] d,
                        output logic [31:0] r);
    @(negedge clk);
    bus_request = 1'b1; bus_write = w; bus_address = a; bus_wdata = d;
    @(negedge clk);
    bus_request = 1'b0; bus_write = 1'b0; bus_address = 3'd0; bus_wdata = '0;
    chk("ack", {31'b0, bus_ack}, 32'h1);
    r = bus_rdata;
  endtask

  initial begin
    reset = 1'b1; bus_request = 1'b0; bus_write = 1'b0; bus_address = '0;
    bus_wdata = '0; pi_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_act", {26'b0, act}, 32'h3C);
    chk("rst_dd", {6'b0, dd_offset}, 32'h03BE_0000);
    chk("rst_save", {6'b0, save_offset}, 32'h03FE_0000);
    chk("rst_flags", {28'b0, pi_hold, update_pending, update_timeout, bus_ack}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    bus_op(1'b0, 3'd0, '0, rd); chk("rd_ctrl", rd, 32'h3C);
    bus_op(1'b0, 3'd1, '0, rd); chk("rd_dd", rd, 32'h03BE_0000);
    bus_op(1'b0, 3'd2, '0, rd); chk("rd_save", rd, 32'h03FE_0000);
    @(negedge clk);
    chk("ack_drop", {31'b0, bus_ack}, 32'h0);
    chk("rdata_idle", bus_rdata, 32'h0);

    // Basic commit, pi idle
    bus_op(1'b1, 3'd0, 32'h01, rd);
    bus_op(1'b1, 3'd3, 32'h0, rd);
    chk("c1_hold0", {30'b0, pi_hold, update_pending}, 32'h3);
    chk("c1_act0", {26'b0, act}, 32'h3C);
    @(negedge clk);
    chk("c1_hold1", {30'b0, pi_hold, update_pending}, 32'h3);
    chk("c1_act1", {26'b0, act}, 32'h3C);
    @(negedge clk);
    chk("c1_hold2", {30'b0, pi_hold, update_pending}, 32'h0);
    chk("c1_act2", {26'b0, act}, 32'h01);

    // Offset masking; active waits for commit
    bus_op(1'b1, 3'd2, 32'h0123_4567, rd);
    bus_op(1'b0, 3'd2, '0, rd); chk("save_rb", rd, 32'h0122_0000);
    chk("save_act_old", {6'b0, save_offset}, 32'h03FE_0000);
    bus_op(1'b1, 3'd3, '0, rd);
    repeat (2) @(negedge clk);
    chk("save_act_new", {6'b0, save_offset}, 32'h0122_0000);

    // Shadow write landing in APPLY is not copied
    bus_op(1'b1, 3'd0, 32'h05, rd);
    bus_op(1'b1, 3'd3, '0, rd);
    bus_op(1'b1, 3'd0, 32'h09, rd);
    chk("apply_wr_act", {26'b0, act}, 32'h05);
    bus_op(1'b0, 3'd0, '0, rd); chk("apply_wr_shadow", rd, 32'h09);

    // PI busy for a while, then goes idle
    pi_busy = 1'b1;
    bus_op(1'b1, 3'd3, '0, rd);
    repeat (10) @(negedge clk);
    bus_op(1'b1, 3'd3, '0, rd);
    chk("busy_pend", {30'b0, pi_hold, update_pending}, 32'h3);
    chk("busy_act", {26'b0, act}, 32'h05);
    pi_busy = 1'b0;
    @(negedge clk);
    chk("busy_apply", {26'b0, act}, 32'h05);
    @(negedge clk);
    chk("busy_done", {26'b0, act}, 32'h09);
    chk("busy_noto", {30'b0, update_timeout, update_pending}, 32'h0);

    // pi_busy falls on the last counted WAIT cycle: APPLY wins
    bus_op(1'b1, 3'd0, 32'h11, rd);
    pi_busy = 1'b1;
    bus_op(1'b1, 3'd3, '0, rd);
    repeat (15) @(negedge clk);
    pi_busy = 1'b0;
    @(negedge clk);
    chk("edge_pend", {30'b0, update_timeout, update_pending}, 32'h1);
    @(negedge clk);
    chk("edge_act", {26'b0, act}, 32'h11);

    // Timeout
    bus_op(1'b1, 3'd0, 32'h22, rd);
    pi_busy = 1'b1;
    bus_op(1'b1, 3'd3, '0, rd);
    repeat (15) @(negedge clk);
    chk("to_before", {30'b0, update_timeout, update_pending}, 32'h1);
    @(negedge clk);
    chk("to_after", {29'b0, pi_hold, update_timeout, update_pending}, 32'h2);
    chk("to_act", {26'b0, act}, 32'h11);
    pi_busy = 1'b0;
    bus_op(1'b0, 3'd4, '0, rd); chk("to_status", rd, 32'h2);
    bus_op(1'b1, 3'd4, 32'h2, rd);
    bus_op(1'b0, 3'd4, '0, rd); chk("to_cleared", rd, 32'h0);

    // Unmapped addresses
    bus_op(1'b1, 3'd7, 32'hFFFF_FFFF, rd);
    bus_op(1'b0, 3'd5, '0, rd); chk("unmapped_rd", rd, 32'h0);
    bus_op(1'b0, 3'd0, '0, rd); chk("unmapped_wr", rd, 32'h22);

    // Reset during WAIT, then a normal commit
    pi_busy = 1'b1;
    bus_op(1'b1, 3'd1, 32'h0ABC_DEF0, rd);
    bus_op(1'b1, 3'd3, '0, rd);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; pi_busy = 1'b0;
    chk("mid_rst_flags", {29'b0, pi_hold, update_timeout, update_pending}, 32'h0);
    chk("mid_rst_act", {26'b0, act}, 32'h3C);
    chk("mid_rst_dd", {6'b0, dd_offset}, 32'h03BE_0000);
    bus_op(1'b0, 3'd1, '0, rd); chk("mid_rst_dd_sh", rd, 32'h03BE_0000);
    bus_op(1'b1, 3'd0, 32'h3F, rd);
    bus_op(1'b1, 3'd1, 32'h0ABC_DEF0, rd);
    bus_op(1'b1, 3'd3, '0, rd);
    repeat (2) @(negedge clk);
    chk("recommit_act", {26'b0, act}, 32'h3F);
    chk("recommit_dd", {6'b0, dd_offset}, 32'h02BC_0000);
    chk("recommit_pend", {31'b0, update_pending}, 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
